// File: rtl/core_pkg.sv
// Shared load-path types: load funct3 encodings, load FSM states and the
// queued load record.
package core_pkg;

  localparam int DEFAULT_TAG_WIDTH = 4;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, BCAST} load_state_t;

  typedef struct packed {
    logic [DEFAULT_TAG_WIDTH-1:0] tag;
    logic [31:0]                  ea;
    logic [2:0]                   funct3;
  } load_entry_t;

endpackage

// File: rtl/load_align.sv
// Little-endian lane select with sign/zero extension for loaded words, plus
// the misalignment / illegal-funct3 fault check for the same access.
module load_align
  import core_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  ea_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data,
  output logic        fault
);

  logic [31:0] shifted;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    data      = '0;
    fault     = 1'b0;
    shifted   = word >> {ea_lo, 3'b000};
    byte_lane = shifted[7:0];
    half_lane = ea_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      LB:  data = {{24{byte_lane[7]}}, byte_lane};
      LBU: data = {24'h0, byte_lane};
      LH: begin
        fault = ea_lo[0];
        if (!fault) data = {{16{half_lane[15]}}, half_lane};
      end
      LHU: begin
        fault = ea_lo[0];
        if (!fault) data = {16'h0, half_lane};
      end
      LW: begin
        fault = (ea_lo != 2'b00);
        if (!fault) data = word;
      end
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// In-order load unit: FIFO of issued loads, one BRAM access in flight at a
// time, aligned result broadcast on the CDB with valid/ready handshake.
module load_unit
  import core_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int TAG_WIDTH      = DEFAULT_TAG_WIDTH,
  parameter int MEM_LATENCY    = 2,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      flush_in,
  input  logic                      issue_valid_in,
  output logic                      issue_ready_out,
  input  logic [TAG_WIDTH-1:0]      issue_tag_in,
  input  logic [31:0]               issue_base_in,
  input  logic [11:0]               issue_offset_in,
  input  logic [2:0]                issue_funct3_in,
  output logic                      mem_req_out,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_out,
  input  logic [31:0]               mem_data_in,
  output logic                      cdb_valid_out,
  input  logic                      cdb_ready_in,
  output logic [TAG_WIDTH-1:0]      cdb_tag_out,
  output logic [31:0]               cdb_data_out,
  output logic                      cdb_exc_out
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int WCNT_W = $clog2(MEM_LATENCY + 1);

  load_entry_t       queue_mem [DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q;
  load_state_t       state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q;
  load_entry_t       work_q;
  logic [31:0]       res_data_q;
  logic              res_exc_q;

  logic        enq, pop, entry_fault;
  logic [31:0] aligned;
  load_entry_t new_entry;
  logic        unused_ea_hi;

  // Ready looks only at the registered count; a same-cycle pop never opens a slot.
  assign issue_ready_out = (count_q != CNT_W'(DEPTH));
  assign enq             = issue_valid_in && issue_ready_out && !flush_in;

  always_comb begin
    new_entry        = '0;
    new_entry.tag    = DEFAULT_TAG_WIDTH'(issue_tag_in);
    new_entry.ea     = issue_base_in + {{20{issue_offset_in[11]}}, issue_offset_in};
    new_entry.funct3 = issue_funct3_in;
  end

  load_align u_align (
    .word   (mem_data_in),
    .ea_lo  (work_q.ea[1:0]),
    .funct3 (work_q.funct3),
    .data   (aligned),
    .fault  (entry_fault)
  );

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    mem_req_out = 1'b0;
    case (state_q)
      IDLE: if (count_q != '0) begin
        pop     = 1'b1;
        state_d = REQ;
      end
      REQ: if (entry_fault) begin
        state_d = BCAST;
      end else begin
        mem_req_out = 1'b1;
        state_d     = WAIT;
      end
      WAIT:    if (wait_cnt_q == WCNT_W'(MEM_LATENCY - 1)) state_d = BCAST;
      BCAST:   if (cdb_ready_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_in) begin
      state_d     = IDLE;
      pop         = 1'b0;
      mem_req_out = 1'b0;
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      work_q     <= '0;
      res_data_q <= '0;
      res_exc_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= (state_q == WAIT && state_d == WAIT) ? wait_cnt_q + WCNT_W'(1) : '0;
      if (pop) work_q <= queue_mem[head_q];
      if (state_q == REQ && entry_fault) begin
        res_data_q <= '0;
        res_exc_q  <= 1'b1;
      end else if (state_q == WAIT && state_d == BCAST) begin
        res_data_q <= aligned;
        res_exc_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq) tail_q <= tail_q + PTR_W'(1);
      if (pop) head_q <= head_q + PTR_W'(1);
      case ({enq, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: queue storage has no reset; head/tail/count decide which slots are meaningful.
  always_ff @(posedge clk_in) begin
    if (enq) queue_mem[tail_q] <= new_entry;
  end

  assign mem_addr_out  = work_q.ea[MEM_ADDR_WIDTH+1:2];
  assign unused_ea_hi  = ^work_q.ea[31:MEM_ADDR_WIDTH+2];
  assign cdb_valid_out = (state_q == BCAST);
  assign cdb_tag_out   = TAG_WIDTH'(work_q.tag);
  assign cdb_data_out  = res_data_q;
  assign cdb_exc_out   = res_exc_q;

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit: table of single loads with hand-computed
// results, then back-to-back, flush and mid-broadcast reset sequences.
module tb_load_unit;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        flush_in = 1'b0;
  logic        issue_valid_in = 1'b0;
  logic        issue_ready_out;
  logic [3:0]  issue_tag_in = '0;
  logic [31:0] issue_base_in = '0;
  logic [11:0] issue_offset_in = '0;
  logic [2:0]  issue_funct3_in = '0;
  logic        mem_req_out;
  logic [9:0]  mem_addr_out;
  logic [31:0] mem_data_in = '0;
  logic        cdb_valid_out;
  logic        cdb_ready_in = 1'b1;
  logic [3:0]  cdb_tag_out;
  logic [31:0] cdb_data_out;
  logic        cdb_exc_out;

  int n_checks = 0;
  int n_fail   = 0;

  load_unit dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .flush_in        (flush_in),
    .issue_valid_in  (issue_valid_in),
    .issue_ready_out (issue_ready_out),
    .issue_tag_in    (issue_tag_in),
    .issue_base_in   (issue_base_in),
    .issue_offset_in (issue_offset_in),
    .issue_funct3_in (issue_funct3_in),
    .mem_req_out     (mem_req_out),
    .mem_addr_out    (mem_addr_out),
    .mem_data_in     (mem_data_in),
    .cdb_valid_out   (cdb_valid_out),
    .cdb_ready_in    (cdb_ready_in),
    .cdb_tag_out     (cdb_tag_out),
    .cdb_data_out    (cdb_data_out),
    .cdb_exc_out     (cdb_exc_out)
  );

  always #5 clk_in = ~clk_in;

  // BRAM model with two-cycle read latency.
  logic [31:0] bram [1024];
  logic [31:0] rd_pipe = '0;
  always @(posedge clk_in) begin
    rd_pipe     <= mem_req_out ? bram[mem_addr_out] : 32'hDEAD_BEEF;
    mem_data_in <= rd_pipe;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [3:0]  tag;
    logic [31:0] base;
    logic [11:0] off;
    logic [2:0]  f3;
    logic [31:0] exp_data;
    logic        exp_exc;
  } vec_t;

  vec_t vecs [13];

  // One load into an idle unit with cdb_ready_in high; checks latency, memory
  // request count/address and the broadcast result.
  task automatic run_load(input vec_t v);
    int          lat, reqs;
    logic [9:0]  addr;
    logic [31:0] ea, data;
    logic [3:0]  tag;
    logic        exc;
    ea   = v.base + {{20{v.off[11]}}, v.off};
    lat  = 0;
    reqs = 0;
    addr = '0;
    data = '0;
    tag  = '0;
    exc  = 1'b0;
    @(negedge clk_in);
    issue_valid_in  = 1'b1;
    issue_tag_in    = v.tag;
    issue_base_in   = v.base;
    issue_offset_in = v.off;
    issue_funct3_in = v.f3;
    check({v.name, "_ready"}, 32'(issue_ready_out), 32'd1);
    @(negedge clk_in);
    issue_valid_in = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (mem_req_out) begin
        reqs++;
        addr = mem_addr_out;
      end
      if (cdb_valid_out) begin
        lat  = k;
        data = cdb_data_out;
        tag  = cdb_tag_out;
        exc  = cdb_exc_out;
        break;
      end
      @(negedge clk_in);
    end
    check({v.name, "_latency"}, 32'(lat), v.exp_exc ? 32'd3 : 32'd5);
    check({v.name, "_data"}, data, v.exp_data);
    check({v.name, "_tag"}, 32'(tag), 32'(v.tag));
    check({v.name, "_exc"}, 32'(exc), 32'(v.exp_exc));
    check({v.name, "_reqs"}, 32'(reqs), v.exp_exc ? 32'd0 : 32'd1);
    if (!v.exp_exc) check({v.name, "_addr"}, 32'(addr), 32'(ea[11:2]));
    @(negedge clk_in);
    check({v.name, "_valid_drop"}, 32'(cdb_valid_out), 32'd0);
  endtask

  initial begin
    int got, pend, pulses, reqs;
    logic seen;

    for (int i = 0; i < 1024; i++) bram[i] = 32'hA000_0000 + 32'(i);
    bram[1] = 32'h8BAD_F00D;
    bram[2] = 32'h80FF_7F01;

    vecs[0]  = '{"lw_w1",     4'd3,  32'd4,          12'h000, 3'b010, 32'h8BAD_F00D, 1'b0};
    vecs[1]  = '{"lb_ea5",    4'd1,  32'd5,          12'h000, 3'b000, 32'hFFFF_FFF0, 1'b0};
    vecs[2]  = '{"lbu_ea5",   4'd2,  32'd5,          12'h000, 3'b100, 32'h0000_00F0, 1'b0};
    vecs[3]  = '{"lh_ea6",    4'd4,  32'd6,          12'h000, 3'b001, 32'hFFFF_8BAD, 1'b0};
    vecs[4]  = '{"lhu_ea4",   4'd5,  32'd4,          12'h000, 3'b101, 32'h0000_F00D, 1'b0};
    vecs[5]  = '{"lw_negoff", 4'd6,  32'd12,         12'hFF8, 3'b010, 32'h8BAD_F00D, 1'b0};
    vecs[6]  = '{"lh_mis",    4'd7,  32'd5,          12'h000, 3'b001, 32'h0000_0000, 1'b1};
    vecs[7]  = '{"f3_011",    4'd8,  32'd4,          12'h000, 3'b011, 32'h0000_0000, 1'b1};
    vecs[8]  = '{"lw_mis",    4'd9,  32'd6,          12'h000, 3'b010, 32'h0000_0000, 1'b1};
    vecs[9]  = '{"lb_ea11",   4'd10, 32'd8,          12'h003, 3'b000, 32'hFFFF_FF80, 1'b0};
    vecs[10] = '{"lh_ea8",    4'd11, 32'd8,          12'h000, 3'b001, 32'h0000_7F01, 1'b0};
    vecs[11] = '{"lw_wrap",   4'd12, 32'hFFFF_FFFC,  12'h008, 3'b010, 32'h8BAD_F00D, 1'b0};
    vecs[12] = '{"f3_110",    4'd13, 32'd4,          12'h000, 3'b110, 32'h0000_0000, 1'b1};

    // Reset state.
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    check("rst_ready",  32'(issue_ready_out), 32'd1);
    check("rst_valid",  32'(cdb_valid_out),   32'd0);
    check("rst_memreq", 32'(mem_req_out),     32'd0);
    check("rst_data",   cdb_data_out,         32'd0);

    for (int i = 0; i < 13; i++) run_load(vecs[i]);

    // Back-to-back with the CDB stalled: one load moves into the working
    // register, so five are accepted before the four-entry queue fills.
    cdb_ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      issue_valid_in  = 1'b1;
      issue_tag_in    = 4'(i);
      issue_base_in   = 32'(4 * i);
      issue_offset_in = '0;
      issue_funct3_in = 3'b010;
      check($sformatf("b2b_ready_%0d", i), 32'(issue_ready_out), 32'd1);
    end
    @(negedge clk_in);
    issue_tag_in  = 4'd5;
    issue_base_in = 32'd20;
    for (int c = 0; c < 4; c++) begin
      check("b2b_full_ready", 32'(issue_ready_out), 32'd0);
      check("b2b_hold_valid", 32'(cdb_valid_out), 32'd1);
      check("b2b_hold_tag",   32'(cdb_tag_out),   32'd0);
      @(negedge clk_in);
    end
    cdb_ready_in = 1'b1;
    got  = 0;
    pend = 0;
    for (int c = 0; c < 200 && got < 6; c++) begin
      if (pend != 0) begin
        issue_valid_in = 1'b0;
        pend = 0;
      end else if (issue_valid_in && issue_ready_out) begin
        pend = 1;
      end
      if (cdb_valid_out) begin
        check($sformatf("b2b_tag_%0d", got),  32'(cdb_tag_out), 32'(got));
        check($sformatf("b2b_data_%0d", got), cdb_data_out,     bram[got]);
        got++;
      end
      @(negedge clk_in);
    end
    issue_valid_in = 1'b0;
    check("b2b_count", 32'(got), 32'd6);
    pulses = 0;
    repeat (10) begin
      if (cdb_valid_out) pulses++;
      @(negedge clk_in);
    end
    check("b2b_no_dup", 32'(pulses), 32'd0);

    // Flush while the first of four loads waits on memory (three queued).
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      issue_valid_in  = 1'b1;
      issue_tag_in    = 4'(8 + i);
      issue_base_in   = 32'(4 * i);
      issue_funct3_in = 3'b010;
    end
    @(negedge clk_in);
    issue_valid_in = 1'b0;
    flush_in = 1'b1;
    @(negedge clk_in);
    flush_in = 1'b0;
    check("flush_ready", 32'(issue_ready_out), 32'd1);
    pulses = 0;
    reqs   = 0;
    repeat (15) begin
      if (cdb_valid_out) pulses++;
      if (mem_req_out) reqs++;
      @(negedge clk_in);
    end
    check("flush_no_cdb", 32'(pulses), 32'd0);
    check("flush_no_req", 32'(reqs),   32'd0);
    run_load(vecs[0]);

    // Reset asserted while a result sits on the CDB.
    cdb_ready_in = 1'b0;
    @(negedge clk_in);
    issue_valid_in  = 1'b1;
    issue_tag_in    = 4'd6;
    issue_base_in   = 32'd4;
    issue_offset_in = '0;
    issue_funct3_in = 3'b010;
    @(negedge clk_in);
    issue_valid_in = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (cdb_valid_out) seen = 1'b1;
      else @(negedge clk_in);
    end
    check("rstmid_bcast_seen", 32'(seen), 32'd1);
    rst_in = 1'b1;
    #1;
    check("rstmid_valid",  32'(cdb_valid_out),   32'd0);
    check("rstmid_tag",    32'(cdb_tag_out),     32'd0);
    check("rstmid_data",   cdb_data_out,         32'd0);
    check("rstmid_exc",    32'(cdb_exc_out),     32'd0);
    check("rstmid_memreq", 32'(mem_req_out),     32'd0);
    check("rstmid_addr",   32'(mem_addr_out),    32'd0);
    check("rstmid_ready",  32'(issue_ready_out), 32'd1);
    @(negedge clk_in);
    rst_in = 1'b0;
    cdb_ready_in = 1'b1;
    pulses = 0;
    reqs   = 0;
    repeat (10) begin
      if (cdb_valid_out) pulses++;
      if (mem_req_out) reqs++;
      @(negedge clk_in);
    end
    check("rstmid_no_cdb", 32'(pulses), 32'd0);
    check("rstmid_no_req", 32'(reqs),   32'd0);
    check("rstmid_ready_after", 32'(issue_ready_out), 32'd1);
    run_load(vecs[3]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
